// File: rtl/instr_aligner.sv
// -----------------------------------------------------------------------------
// instr_aligner
//
// Sits between the instruction fetch buffer and the compressed decoder. It
// takes 32-bit word-aligned fetch words and hands out one instruction per
// handshake, tracking 16-bit alignment. A 32-bit instruction that straddles
// two fetch words is rebuilt from a one-halfword holding register.
//
// Ports:
//   clk_i                  clock
//   rst_ni                 synchronous active-low reset
//   fetch_valid_i          fetch word valid
//   fetch_ready_o          fetch word consumed this cycle
//   fetch_rdata_i[31:0]    fetch word, little-endian halfwords
//   fetch_addr_i           byte address of the fetch word (bits [1:0] = 00)
//   flush_i                redirect; held state is discarded
//   flush_pc_i             redirect target (halfword aligned)
//   instr_valid_o          instruction valid
//   instr_ready_i          downstream accepts the instruction
//   instr_o[31:0]          raw instruction, compressed ones zero-extended
//   instr_pc_o             byte address of the instruction
//   instr_is_compressed_o  instr_o[1:0] != 2'b11
// -----------------------------------------------------------------------------
module instr_aligner #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fetch_valid_i,
    output logic              fetch_ready_o,
    input  logic [31:0]       fetch_rdata_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_is_compressed_o
);

    // Operating mode, derived each cycle from the holding/skip registers.
    typedef enum logic [1:0] {
        M_EMPTY,   // nothing held, instruction starts at the low half
        M_SKIP,    // branch target was the upper half; ignore the low half
        M_HELD_C,  // held halfword is a full compressed instruction
        M_HELD_U   // held halfword is the low half of a 32-bit instruction
    } mode_e;

    logic [15:0]       hw_q, hw_d;
    logic [ADDR_W-1:0] hw_pc_q, hw_pc_d;
    logic              hw_valid_q, hw_valid_d;
    logic              skip_lo_q, skip_lo_d;

    mode_e             mode;
    logic [ADDR_W-1:0] addr_plus2;
    logic              lo_is_c;
    logic              hi_is_c;

    // Only bit 1 of the redirect target matters; a word fetch restarts at [1:0]=00.
    logic unused_flush_pc;
    assign unused_flush_pc = ^{flush_pc_i[ADDR_W-1:2], flush_pc_i[0]};

    assign addr_plus2 = fetch_addr_i + ADDR_W'(2);
    assign lo_is_c    = (fetch_rdata_i[1:0]   != 2'b11);
    assign hi_is_c    = (fetch_rdata_i[17:16] != 2'b11);

    always_comb begin
        if (hw_valid_q) begin
            mode = (hw_q[1:0] != 2'b11) ? M_HELD_C : M_HELD_U;
        end else if (skip_lo_q) begin
            mode = M_SKIP;
        end else begin
            mode = M_EMPTY;
        end
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no
        // path through the case below can leave one unassigned and infer a latch.
        hw_d                  = hw_q;
        hw_pc_d               = hw_pc_q;
        hw_valid_d            = hw_valid_q;
        skip_lo_d             = skip_lo_q;
        instr_valid_o         = 1'b0;
        fetch_ready_o         = 1'b0;
        instr_o               = 32'h0;
        instr_pc_o            = '0;
        instr_is_compressed_o = 1'b0;

        unique case (mode)
            M_EMPTY: begin
                instr_valid_o = fetch_valid_i;
                instr_pc_o    = fetch_addr_i;
                fetch_ready_o = instr_ready_i & fetch_valid_i;
                if (lo_is_c) begin
                    instr_o               = {16'h0, fetch_rdata_i[15:0]};
                    instr_is_compressed_o = 1'b1;
                    // Upper half is kept; it is either a compressed instruction
                    // or the first half of a straddling 32-bit one.
                    if (fetch_ready_o) begin
                        hw_d       = fetch_rdata_i[31:16];
                        hw_pc_d    = addr_plus2;
                        hw_valid_d = 1'b1;
                    end
                end else begin
                    instr_o = fetch_rdata_i;
                end
            end

            M_SKIP: begin
                if (hi_is_c) begin
                    instr_valid_o         = fetch_valid_i;
                    instr_o               = {16'h0, fetch_rdata_i[31:16]};
                    instr_pc_o            = addr_plus2;
                    instr_is_compressed_o = 1'b1;
                    fetch_ready_o         = instr_ready_i & fetch_valid_i;
                    if (fetch_ready_o) begin
                        skip_lo_d = 1'b0;
                    end
                end else begin
                    // Nothing to emit yet: swallow the word and hold its upper
                    // half until the next word completes the instruction.
                    fetch_ready_o = fetch_valid_i;
                    if (fetch_valid_i) begin
                        hw_d       = fetch_rdata_i[31:16];
                        hw_pc_d    = addr_plus2;
                        hw_valid_d = 1'b1;
                        skip_lo_d  = 1'b0;
                    end
                end
            end

            M_HELD_C: begin
                instr_valid_o         = 1'b1;
                instr_o               = {16'h0, hw_q};
                instr_pc_o            = hw_pc_q;
                instr_is_compressed_o = 1'b1;
                if (instr_ready_i) begin
                    hw_valid_d = 1'b0;
                end
            end

            M_HELD_U: begin
                instr_valid_o = fetch_valid_i;
                instr_o       = {fetch_rdata_i[15:0], hw_q};
                instr_pc_o    = hw_pc_q;
                fetch_ready_o = instr_ready_i & fetch_valid_i;
                if (fetch_ready_o) begin
                    hw_d    = fetch_rdata_i[31:16];
                    hw_pc_d = addr_plus2;
                end
            end

            default: ;
        endcase

        // Redirect overrides everything: drop the stale word and restart.
        if (flush_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b1;
            hw_valid_d    = 1'b0;
            skip_lo_d     = flush_pc_i[1];
        end

        // Outputs stay quiet throughout reset.
        if (!rst_ni) begin
            instr_valid_o         = 1'b0;
            fetch_ready_o         = 1'b0;
            instr_o               = 32'h0;
            instr_pc_o            = '0;
            instr_is_compressed_o = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hw_q       <= 16'h0;
            hw_pc_q    <= '0;
            hw_valid_q <= 1'b0;
            skip_lo_q  <= 1'b0;
        end else begin
            hw_q       <= hw_d;
            hw_pc_q    <= hw_pc_d;
            hw_valid_q <= hw_valid_d;
            skip_lo_q  <= skip_lo_d;
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// -----------------------------------------------------------------------------
// tb_instr_aligner
//
// Directed bench for instr_aligner. Expected instructions are pushed to a
// scoreboard queue when the stimulus is driven; a monitor pops and compares
// them whenever the DUT transfers an instruction. Direct checks cover reset,
// flush and stall behaviour of the handshake signals.
// -----------------------------------------------------------------------------
module tb_instr_aligner;

    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
        logic              comp;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              fetch_valid_i;
    logic              fetch_ready_o;
    logic [31:0]       fetch_rdata_i;
    logic [ADDR_W-1:0] fetch_addr_i;
    logic              flush_i;
    logic [ADDR_W-1:0] flush_pc_i;
    logic              instr_valid_o;
    logic              instr_ready_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_is_compressed_o;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    instr_aligner #(.ADDR_W(ADDR_W)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_ready_o         (fetch_ready_o),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_addr_i          (fetch_addr_i),
        .flush_i               (flush_i),
        .flush_pc_i            (flush_pc_i),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_o               (instr_o),
        .instr_pc_o            (instr_pc_o),
        .instr_is_compressed_o (instr_is_compressed_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [ADDR_W-1:0] pc, input logic comp);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.comp  = comp;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] rdata, input logic [ADDR_W-1:0] addr);
        fetch_valid_i = v;
        fetch_rdata_i = rdata;
        fetch_addr_i  = addr;
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && instr_valid_o === 1'b1 && instr_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_instr", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_instr", 64'(instr_o), 64'(e.instr));
                check("sb_pc",    64'(instr_pc_o), 64'(e.pc));
                check("sb_comp",  64'(instr_is_compressed_o), 64'(e.comp));
            end
        end
    end

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        flush_pc_i    = '0;
        instr_ready_i = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100);

        // Reset: outputs silent even with a valid word presented.
        @(negedge clk_i);
        check("rst_valid", 64'(instr_valid_o), 64'd0);
        check("rst_fready", 64'(fetch_ready_o), 64'd0);
        check("rst_instr", 64'(instr_o), 64'd0);
        check("rst_pc", 64'(instr_pc_o), 64'd0);
        check("rst_comp", 64'(instr_is_compressed_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;

        // Two aligned 32-bit instructions.
        drive(1'b1, 32'h00500093, 32'h100);
        push(32'h00500093, 32'h100, 1'b0);
        @(negedge clk_i);
        check("t1_fready0", 64'(fetch_ready_o), 64'd1);
        tick();
        drive(1'b1, 32'h00A00113, 32'h104);
        push(32'h00A00113, 32'h104, 1'b0);
        @(negedge clk_i);
        check("t1_fready1", 64'(fetch_ready_o), 64'd1);
        tick();

        // Two compressed instructions in one word.
        drive(1'b1, 32'h45854501, 32'h100);
        push(32'h00004501, 32'h100, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        push(32'h00004585, 32'h102, 1'b1);
        @(negedge clk_i);
        check("t2_fready_held", 64'(fetch_ready_o), 64'd0);
        tick();
        @(negedge clk_i);
        check("t2_empty_idle", 64'(instr_valid_o), 64'd0);

        // Straddling 32-bit instruction, then a trailing compressed zero.
        drive(1'b1, 32'h05134501, 32'h100);
        push(32'h00004501, 32'h100, 1'b1);
        tick();
        drive(1'b1, 32'h00000010, 32'h104);
        push(32'h00100513, 32'h102, 1'b0);
        @(negedge clk_i);
        check("t3_fready_straddle", 64'(fetch_ready_o), 64'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        push(32'h00000000, 32'h106, 1'b1);
        tick();

        // Flush to an upper-half target with a stale word present.
        flush_i    = 1'b1;
        flush_pc_i = 32'h202;
        drive(1'b1, 32'hDEADBEEF, 32'h500);
        @(negedge clk_i);
        check("t4_flush_valid", 64'(instr_valid_o), 64'd0);
        check("t4_flush_fready", 64'(fetch_ready_o), 64'd1);
        tick();
        flush_i = 1'b0;
        drive(1'b1, 32'h45850001, 32'h200);
        push(32'h00004585, 32'h202, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("t4_after_skip_idle", 64'(instr_valid_o), 64'd0);
        tick();

        // Flush to an upper-half target that starts a 32-bit instruction.
        flush_i    = 1'b1;
        flush_pc_i = 32'h202;
        tick();
        flush_i = 1'b0;
        drive(1'b1, 32'h05130001, 32'h200);
        @(negedge clk_i);
        check("t4b_skip_valid", 64'(instr_valid_o), 64'd0);
        check("t4b_skip_fready", 64'(fetch_ready_o), 64'd1);
        tick();
        drive(1'b1, 32'h00000010, 32'h204);
        push(32'h00100513, 32'h202, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        push(32'h00000000, 32'h206, 1'b1);
        tick();

        // Downstream stall while a straddling instruction is pending.
        drive(1'b1, 32'h05134501, 32'h100);
        push(32'h00004501, 32'h100, 1'b1);
        tick();
        instr_ready_i = 1'b0;
        drive(1'b1, 32'h00000010, 32'h104);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t5_stall_valid", 64'(instr_valid_o), 64'd1);
            check("t5_stall_instr", 64'(instr_o), 64'h00100513);
            check("t5_stall_pc", 64'(instr_pc_o), 64'h102);
            check("t5_stall_fready", 64'(fetch_ready_o), 64'd0);
            tick();
        end
        instr_ready_i = 1'b1;
        push(32'h00100513, 32'h102, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        push(32'h00000000, 32'h106, 1'b1);
        tick();

        // Reset while a halfword is held discards it.
        drive(1'b1, 32'h45854501, 32'h100);
        push(32'h00004501, 32'h100, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("t6_rst_valid", 64'(instr_valid_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        drive(1'b1, 32'h00500093, 32'h300);
        push(32'h00500093, 32'h300, 1'b0);
        @(negedge clk_i);
        check("t6_post_rst_valid", 64'(instr_valid_o), 64'd1);
        tick();

        // Top of the address space.
        drive(1'b1, 32'h45854501, 32'hFFFFFFFC);
        push(32'h00004501, 32'hFFFFFFFC, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        push(32'h00004585, 32'hFFFFFFFE, 1'b1);
        tick();
        tick();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
